// File: rtl/fb_pkg.sv
// Shared constants and types for the double-buffered framebuffer arbiter.
package fb_pkg;

    localparam int unsigned FB_W    = 320;
    localparam int unsigned FB_H    = 180;
    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int unsigned AW      = 17;
    localparam int unsigned DW      = 8;

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Drawing-client port: write handshake plus buffer-swap control.
interface vga_fb_arbiter_if;
    import fb_pkg::*;

    logic          wr_req;
    logic [8:0]    wr_x;
    logic [7:0]    wr_y;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          swap_req;
    logic          swap_pending;
    logic          front;

    modport master (
        output wr_req, wr_x, wr_y, wr_data, swap_req,
        input  wr_ack, swap_pending, front
    );

    modport slave (
        input  wr_req, wr_x, wr_y, wr_data, swap_req,
        output wr_ack, swap_pending, front
    );

endinterface

// File: rtl/fb_addr.sv
// Framebuffer address: buf*FB_SIZE + y*320 + x, built from shifts and adds.
module fb_addr
    import fb_pkg::*;
(
    input  logic          buf_sel,
    input  logic [9:0]    x,
    input  logic [8:0]    y,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] base;
    logic [AW-1:0] y256;
    logic [AW-1:0] y64;
    logic [AW-1:0] xe;

    // y*320 = (y<<8) + (y<<6); the buffer select adds a whole frame offset
    always_comb begin
        base = buf_sel ? AW'(FB_SIZE) : '0;
        y256 = AW'(y) << 8;
        y64  = AW'(y) << 6;
        xe   = AW'(x);
        addr = base + y256 + y64 + xe;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads have hard priority, the
// drawing client fills remaining cycles, and buffer swaps wait for screen end.
module vga_fb_arbiter
    import fb_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pix_stb,
    input  logic [9:0]           i_x,
    input  logic [8:0]           i_y,
    input  logic                 i_active,
    input  logic                 i_screenend,
    output logic [AW-1:0]        o_ram_addr,
    output logic                 o_ram_we,
    output logic [DW-1:0]        o_ram_wdata,
    input  logic [DW-1:0]        i_ram_rdata,
    output logic [DW-1:0]        o_colour,
    vga_fb_arbiter_if.slave      client
);

    logic          scan_slot;
    logic          blank_slot;
    logic          end_stb;
    logic          grant;
    logic          in_range;
    logic [AW-1:0] scan_addr;
    logic [AW-1:0] client_addr;
    logic          rd_pending;
    logic          blank_pending;
    logic          front;
    logic          toggle;
    swap_state_t   state;
    swap_state_t   state_next;

    assign scan_slot  = i_pix_stb & i_active;
    assign blank_slot = i_pix_stb & ~i_active;
    assign end_stb    = i_pix_stb & i_screenend;
    assign in_range   = (32'(client.wr_x) < FB_W) && (32'(client.wr_y) < FB_H);

    // Ack is the grant itself, so the client sees it in the cycle it is served
    assign grant         = client.wr_req & ~scan_slot & ~i_rst;
    assign client.wr_ack = grant;

    assign client.front        = front;
    assign client.swap_pending = (state == PENDING);

    fb_addr u_scan_addr (
        .buf_sel (front),
        .x       (i_x),
        .y       (i_y),
        .addr    (scan_addr)
    );

    fb_addr u_client_addr (
        .buf_sel (~front),
        .x       ({1'b0, client.wr_x}),
        .y       ({1'b0, client.wr_y}),
        .addr    (client_addr)
    );

    // Registered RAM port: scanout read, else client write, else hold address
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ram_addr  <= '0;
            o_ram_we    <= 1'b0;
            o_ram_wdata <= '0;
        end else if (scan_slot) begin
            o_ram_addr <= scan_addr;
            o_ram_we   <= 1'b0;
        end else if (grant) begin
            o_ram_addr  <= client_addr;
            o_ram_we    <= in_range;
            o_ram_wdata <= client.wr_data;
        end else begin
            o_ram_we <= 1'b0;
        end
    end

    // Capture read data the cycle after a scanout slot; blank slots force black
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pending    <= 1'b0;
            blank_pending <= 1'b0;
            o_colour      <= '0;
        end else begin
            rd_pending    <= scan_slot;
            blank_pending <= blank_slot;
            if (rd_pending) begin
                o_colour <= i_ram_rdata;
            end else if (blank_pending) begin
                o_colour <= '0;
            end
        end
    end

    // Swap state and front-buffer index
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            front <= 1'b0;
        end else begin
            state <= state_next;
            if (toggle) begin
                front <= ~front;
            end
        end
    end

    // A request landing on the screen-end strobe swaps at once without pending
    always_comb begin
        state_next = state;
        toggle     = 1'b0;
        case (state)
            IDLE: begin
                if (client.swap_req) begin
                    if (end_stb) begin
                        toggle = 1'b1;
                    end else begin
                        state_next = PENDING;
                    end
                end
            end
            PENDING: begin
                if (end_stb) begin
                    toggle     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a behavioural RAM and model.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_stb;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        active;
    logic        screenend;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  colour;

    vga_fb_arbiter_if bus ();

    vga_fb_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pix_stb   (pix_stb),
        .i_x         (x),
        .i_y         (y),
        .i_active    (active),
        .i_screenend (screenend),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_colour    (colour),
        .client      (bus.slave)
    );

    always #5 clk = ~clk;

    // Bench RAM: unwritten words read a deterministic seed pattern
    logic [7:0] ram   [0:115199];
    bit         valid [0:115199];
    logic [7:0] model_mem [0:115199];
    logic        bd_we = 1'b0;
    int          bd_addr;
    logic [7:0]  bd_data;

    function automatic logic [7:0] seed(input int a);
        return 8'((a * 29 + (a >> 7)) ^ 32'h5A);
    endfunction

    function automatic int maddr(input int b, input int xx, input int yy);
        return b * 57600 + yy * 320 + xx;
    endfunction

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr]   <= bd_data;
            valid[bd_addr] <= 1'b1;
        end else if (ram_we && ram_addr < 17'd115200) begin
            ram[ram_addr]   <= ram_wdata;
            valid[ram_addr] <= 1'b1;
        end
    end

    assign ram_rdata = (ram_addr < 17'd115200)
                     ? (valid[ram_addr] ? ram[ram_addr] : seed(int'(ram_addr)))
                     : 8'h00;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m_front   = 0;
    int m_pending = 0;

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs;
        pix_stb = 0; active = 0; screenend = 0; x = '0; y = '0;
        bus.wr_req = 0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
        bus.swap_req = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        bus.wr_req = 1;
        bus.swap_req = 1;
        #1;
        checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack_prio: got %0b expected 0", bus.wr_ack); end
        step();
        step();
        checks++; if (bus.front !== 1'b0) begin errors++; $display("FAIL reset_front: got %0b expected 0", bus.front); end
        checks++; if (bus.swap_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b expected 0", bus.swap_pending); end
        checks++; if (colour !== 8'h00) begin errors++; $display("FAIL reset_colour: got %0h expected 0", colour); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", ram_we); end
        checks++; if (ram_addr !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
        checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", ram_wdata); end
        idle_inputs();
        rst = 0;
        m_front = 0;
        m_pending = 0;
        step();
    endtask

    task automatic test_idle_frame;
        int due = 0;
        logic [7:0] expv = 8'h00;
        for (int i = 0; i < 400; i++) begin
            pix_stb = (i % 4 == 0);
            active  = ($urandom_range(0, 3) != 0);
            x = 10'($urandom_range(0, 319));
            y = 9'($urandom_range(0, 179));
            #1;
            checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL idle_ack: got %0b expected 0", bus.wr_ack); end
            if (pix_stb) begin
                due  = 2;
                expv = active ? model_mem[maddr(m_front, int'(x), int'(y))] : 8'h00;
            end
            step();
            checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %0b expected 0", ram_we); end
            if (due > 0) begin
                due--;
                if (due == 0) begin
                    checks++; if (colour !== expv) begin errors++; $display("FAIL idle_colour: got %0h expected %0h", colour, expv); end
                end
            end
        end
        idle_inputs();
        step();
        checks++; if (bus.front !== 1'b0) begin errors++; $display("FAIL idle_front: got %0b expected 0", bus.front); end
    endtask

    task automatic test_scan_read;
        idle_inputs();
        bd_addr = 325; bd_data = 8'hA5; bd_we = 1;
        model_mem[325] = 8'hA5;
        step();
        bd_we = 0;
        pix_stb = 1; active = 1; x = 10'd5; y = 9'd1;
        step();
        pix_stb = 0; active = 0;
        checks++; if (ram_addr !== 17'd325) begin errors++; $display("FAIL scan_addr: got %0d expected 325", ram_addr); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL scan_we: got %0b expected 0", ram_we); end
        step();
        checks++; if (colour !== 8'hA5) begin errors++; $display("FAIL scan_colour: got %0h expected a5", colour); end
    endtask

    task automatic test_write_defer;
        idle_inputs();
        pix_stb = 1; active = 1; x = 10'd10; y = 9'd2;
        bus.wr_req = 1; bus.wr_x = 9'd319; bus.wr_y = 8'd179; bus.wr_data = 8'h3C;
        #1;
        checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL defer_ack_scan: got %0b expected 0", bus.wr_ack); end
        step();
        checks++; if (ram_addr !== 17'd650) begin errors++; $display("FAIL defer_scan_addr: got %0d expected 650", ram_addr); end
        pix_stb = 0; active = 0;
        #1;
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL defer_ack_grant: got %0b expected 1", bus.wr_ack); end
        model_mem[115199] = 8'h3C;
        step();
        checks++; if (ram_addr !== 17'd115199) begin errors++; $display("FAIL defer_wr_addr: got %0d expected 115199", ram_addr); end
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL defer_wr_we: got %0b expected 1", ram_we); end
        checks++; if (ram_wdata !== 8'h3C) begin errors++; $display("FAIL defer_wr_data: got %0h expected 3c", ram_wdata); end
        bus.wr_req = 0;
        #1;
        checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL defer_ack_drop: got %0b expected 0", bus.wr_ack); end
        step();
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL defer_we_drop: got %0b expected 0", ram_we); end
    endtask

    task automatic test_oob_write;
        idle_inputs();
        bus.wr_req = 1; bus.wr_x = 9'd320; bus.wr_y = 8'd0; bus.wr_data = 8'h77;
        #1;
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL oob_ack: got %0b expected 1", bus.wr_ack); end
        step();
        bus.wr_req = 0;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL oob_we: got %0b expected 0", ram_we); end
        step();
    endtask

    task automatic test_swap;
        idle_inputs();
        bus.swap_req = 1;
        step();
        bus.swap_req = 0;
        checks++; if (bus.swap_pending !== 1'b1) begin errors++; $display("FAIL swap_pending_set: got %0b expected 1", bus.swap_pending); end
        checks++; if (bus.front !== 1'b0) begin errors++; $display("FAIL swap_front_hold: got %0b expected 0", bus.front); end
        step();
        bus.swap_req = 1;
        step();
        bus.swap_req = 0;
        checks++; if (bus.swap_pending !== 1'b1 || bus.front !== 1'b0) begin errors++; $display("FAIL swap_second_req: got pending=%0b front=%0b expected pending=1 front=0", bus.swap_pending, bus.front); end
        pix_stb = 1; screenend = 1;
        step();
        pix_stb = 0; screenend = 0;
        checks++; if (bus.front !== 1'b1) begin errors++; $display("FAIL swap_front_flip: got %0b expected 1", bus.front); end
        checks++; if (bus.swap_pending !== 1'b0) begin errors++; $display("FAIL swap_pending_clr: got %0b expected 0", bus.swap_pending); end
        m_front = 1;
        step();
        checks++; if (bus.front !== 1'b1) begin errors++; $display("FAIL swap_no_double: got %0b expected 1", bus.front); end
        pix_stb = 1; active = 1; x = 10'd319; y = 9'd179;
        step();
        pix_stb = 0; active = 0;
        checks++; if (ram_addr !== 17'd115199) begin errors++; $display("FAIL swap_read_addr: got %0d expected 115199", ram_addr); end
        step();
        checks++; if (colour !== 8'h3C) begin errors++; $display("FAIL swap_read_colour: got %0h expected 3c", colour); end
    endtask

    task automatic test_swap_coincide;
        idle_inputs();
        bus.swap_req = 1; pix_stb = 1; screenend = 1;
        step();
        idle_inputs();
        m_front = 1 - m_front;
        checks++; if (bus.front !== 1'(m_front)) begin errors++; $display("FAIL coincide_front: got %0b expected %0d", bus.front, m_front); end
        checks++; if (bus.swap_pending !== 1'b0) begin errors++; $display("FAIL coincide_pending: got %0b expected 0", bus.swap_pending); end
        step();
        checks++; if (bus.swap_pending !== 1'b0) begin errors++; $display("FAIL coincide_pending_late: got %0b expected 0", bus.swap_pending); end
    endtask

    task automatic test_random_traffic;
        int         due_q[$];
        logic [7:0] val_q[$];
        bit         req_on = 0;
        int         wx_i = 0, wy_i = 0, exp_addr = 0;
        logic [7:0] wd = 8'h00, ev;
        bit         scan, exp_ack, end_stb, inr, chk_addr, exp_we;
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            pix_stb   = ($urandom_range(0, 2) == 0);
            active    = ($urandom_range(0, 3) != 0);
            x         = 10'($urandom_range(0, 319));
            y         = 9'($urandom_range(0, 179));
            screenend = pix_stb && ($urandom_range(0, 15) == 0);
            bus.swap_req = ($urandom_range(0, 19) == 0);
            if (!req_on && $urandom_range(0, 1) == 1) begin
                req_on = 1;
                wx_i = $urandom_range(0, 330);
                wy_i = $urandom_range(0, 185);
                wd   = 8'($urandom);
            end
            bus.wr_req  = req_on;
            bus.wr_x    = 9'(wx_i);
            bus.wr_y    = 8'(wy_i);
            bus.wr_data = wd;
            scan    = pix_stb && active;
            exp_ack = req_on && !scan;
            inr     = (wx_i < 320) && (wy_i < 180);
            end_stb = pix_stb && screenend;
            #1;
            checks++; if (bus.wr_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack: cyc %0d got %0b expected %0b", cyc, bus.wr_ack, exp_ack); end
            if (pix_stb) begin
                due_q.push_back(cyc + 2);
                val_q.push_back(active ? model_mem[maddr(m_front, int'(x), int'(y))] : 8'h00);
            end
            chk_addr = 0;
            exp_we   = 0;
            if (scan) begin
                chk_addr = 1;
                exp_addr = maddr(m_front, int'(x), int'(y));
            end else if (exp_ack) begin
                chk_addr = 1;
                exp_addr = maddr(1 - m_front, wx_i, wy_i);
                exp_we   = inr;
                if (inr) model_mem[exp_addr] = wd;
                req_on = 0;
            end
            if (m_pending == 0 && bus.swap_req) begin
                if (end_stb) m_front = 1 - m_front;
                else m_pending = 1;
            end else if (m_pending == 1 && end_stb) begin
                m_front   = 1 - m_front;
                m_pending = 0;
            end
            step();
            checks++; if (ram_we !== exp_we) begin errors++; $display("FAIL rnd_we: cyc %0d got %0b expected %0b", cyc, ram_we, exp_we); end
            if (chk_addr) begin
                checks++; if (ram_addr !== 17'(exp_addr)) begin errors++; $display("FAIL rnd_addr: cyc %0d got %0d expected %0d", cyc, ram_addr, exp_addr); end
            end
            if (exp_we) begin
                checks++; if (ram_wdata !== wd) begin errors++; $display("FAIL rnd_wdata: cyc %0d got %0h expected %0h", cyc, ram_wdata, wd); end
            end
            checks++; if (bus.front !== 1'(m_front) || bus.swap_pending !== 1'(m_pending)) begin
                errors++; $display("FAIL rnd_swap: cyc %0d got front=%0b pending=%0b expected front=%0d pending=%0d", cyc, bus.front, bus.swap_pending, m_front, m_pending);
            end
            while (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                ev = val_q.pop_front();
                checks++; if (colour !== ev) begin errors++; $display("FAIL rnd_colour: cyc %0d got %0h expected %0h", cyc, colour, ev); end
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_pending;
        idle_inputs();
        bus.swap_req = 1;
        step();
        bus.swap_req = 0;
        checks++; if (bus.swap_pending !== 1'b1) begin errors++; $display("FAIL rstp_pending_set: got %0b expected 1", bus.swap_pending); end
        rst = 1;
        pix_stb = 1; screenend = 1;
        step();
        idle_inputs();
        rst = 0;
        m_front = 0;
        m_pending = 0;
        checks++; if (bus.swap_pending !== 1'b0) begin errors++; $display("FAIL rstp_pending: got %0b expected 0", bus.swap_pending); end
        checks++; if (bus.front !== 1'b0) begin errors++; $display("FAIL rstp_front: got %0b expected 0", bus.front); end
        step();
    endtask

    initial begin
        for (int i = 0; i < 115200; i++) model_mem[i] = seed(i);
        rst = 1;
        idle_inputs();
        test_reset();
        test_idle_frame();
        test_scan_read();
        test_write_defer();
        test_oob_write();
        test_swap();
        test_swap_coincide();
        test_random_traffic();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Owns the single RAM port of a double-buffered 320x180, 8-bit-per-pixel framebuffer.
- Shares that port between two users: display scanout, which is hard priority and is timed by the 320x180 VGA timing generator's strobe/x/y/active outputs, and a drawing client using a req/ack write handshake.
- Sequences front/back buffer swaps so they land only at end of screen. The frame is never torn.
- Sits between the VGA timing generator, the framebuffer block RAM and the drawing engine.

Parameters:
- FB_W, 320, framebuffer width in pixels
- FB_H, 180, framebuffer height in lines
- DW, 8, pixel data width
- AW, 17, RAM address width; must hold 2*FB_W*FB_H = 115200 words

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_pix_stb  in  1  pixel strobe, one i_clk cycle per pixel (e.g. 1 in 4)
- i_x  in  10  scanout x, 0..319 (halved)
- i_y  in  9  scanout y, 0..179 (halved)
- i_active  in  1  high during active drawing
- i_screenend  in  1  high during the last pixel period of the screen
- o_ram_addr  out  AW  RAM address
- o_ram_we  out  1  RAM write enable
- o_ram_wdata  out  DW  RAM write data
- i_ram_rdata  in  DW  RAM read data, valid 1 cycle after address
- o_colour  out  DW  pixel colour to DAC
- i_wr_req  in  1  client write request; held until ack
- i_wr_x  in  9  client pixel x
- i_wr_y  in  8  client pixel y
- i_wr_data  in  DW  client pixel value
- o_wr_ack  out  1  one-cycle pulse: request consumed
- i_swap_req  in  1  one-cycle pulse: back buffer complete
- o_swap_pending  out  1  swap requested, not yet performed
- o_front  out  1  current front buffer index (0/1)

Behaviour:
- Reset values: o_front=0, o_swap_pending=0, o_colour=0, o_wr_ack=0, o_ram_we=0, o_ram_addr=0, o_ram_wdata=0. Reset takes priority over every other event in the same cycle.
- Address: addr(buf,x,y) = buf*57600 + (y<<8) + (y<<6) + x. Implemented with shifts/adds only, no multiplier. Evaluated at AW bits.
- RAM outputs are registered and are decided once per cycle by the arbiter.
- Scanout slot: cycle with i_pix_stb & i_active.
  - Scanout issues a read at addr(o_front, i_x, i_y), with we=0.
  - Exactly one cycle later, the cycle after the slot, o_colour <= i_ram_rdata.
  - Net latency from strobe to o_colour is 2 i_clk cycles (address register + RAM).
- Blank slot: cycle with i_pix_stb & ~i_active. o_colour <= 0 at the same time a read would be captured. The cycle remains free for the client.
- Client slot: any cycle that is not a scanout slot while i_wr_req=1.
  - Issue a write at addr(~o_front, i_wr_x, i_wr_y) with we=1 and wdata=i_wr_data.
  - Pulse o_wr_ack in that same cycle, combinationally tied to the grant.
  - The client drops or changes the request on the following cycle.
- Out-of-range write (i_wr_x>=FB_W or i_wr_y>=FB_H): acked as normal, we=0, nothing written.
- Idle cycle: we=0; address holds its previous value.
- Writes always target the back buffer. The front buffer is never written.
- Swap FSM, states IDLE / PENDING:
  - IDLE -> PENDING on i_swap_req.
  - PENDING -> IDLE on i_pix_stb & i_screenend; o_front toggles in that cycle.
  - i_swap_req while PENDING: ignored, no double toggle.
  - i_swap_req coinciding with i_pix_stb & i_screenend in IDLE: the swap is performed immediately; o_swap_pending never rises.
  - i_screenend in IDLE: no change.
- A write acked in the swap cycle uses the pre-toggle back buffer.
- o_swap_pending is a registered state bit. The client must not start the next frame's drawing while it is high.

Decomposition:
- Package fb_pkg: FB_W, FB_H, FB_SIZE=57600, AW, DW, swap state enum {IDLE, PENDING}.
- One sub-module, fb_addr: combinational (buf, x, y) -> AW address using shift-add. Instantiated twice, for scanout and client.

Test Plan:
- Reset then run a full frame with no client → o_front=0, o_wr_ack never high, we never high, o_colour=0 during blanking.
- Preload buf0[y=1,x=5]=8'hA5; strobe with x=5, y=1, active → o_ram_addr=325 in the next cycle; o_colour=8'hA5 two cycles after the strobe.
- i_wr_req held from a scanout cycle, x=319, y=179, data=8'h3C, front=0 → ack is deferred past the scanout slot, then a write at addr 115199 with we=1; ack is a single one-cycle pulse.
- Write with x=320, y=0 → o_wr_ack pulses, o_ram_we stays 0.
- i_swap_req mid-frame → o_swap_pending=1 until the screenend strobe; o_front flips 0→1 exactly there. A second swap_req while pending causes no extra toggle.
- i_swap_req in the same cycle as the screenend strobe → o_front toggles that cycle, o_swap_pending stays 0. i_rst asserted while PENDING → pending=0, front=0.
